// File: rtl/artix7_pll_drp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : artix7_pll_drp_pkg
// Description : Shared definitions for the PLLE2_ADV DRP retuning controller.
//               Holds the FSM state encoding, the CLKOUTn DRP address map, the
//               read-modify-write keep masks and the divider encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package artix7_pll_drp_pkg;

    typedef enum logic [3:0] {
        ST_INIT      = 4'd0,
        ST_WAIT_LOCK = 4'd1,
        ST_IDLE      = 4'd2,
        ST_SEL       = 4'd3,
        ST_RD        = 4'd4,
        ST_RD_WAIT   = 4'd5,
        ST_WR        = 4'd6,
        ST_WR_WAIT   = 4'd7,
        ST_RELEASE   = 4'd8
    } state_t;

    // Bits preserved from the current register contents during a rewrite
    // (phase mux / delay fields the controller never touches).
    localparam logic [15:0] c_KEEP_REG1 = 16'hF000;
    localparam logic [15:0] c_KEEP_REG2 = 16'hFF3F;

    // Reg1 of every CLKOUTn sits at an even address, Reg2 directly above it.
    function automatic logic [6:0] drp_addr(input logic [2:0] lane, input logic reg2);
        logic [6:0] base;
        case (lane)
            3'd0:    base = 7'h08;
            3'd1:    base = 7'h0A;
            3'd2:    base = 7'h0C;
            3'd3:    base = 7'h0E;
            3'd4:    base = 7'h10;
            3'd5:    base = 7'h06;
            default: base = 7'h08;
        endcase
        return {base[6:1], reg2};
    endfunction

    function automatic logic [15:0] keep_mask(input logic reg2);
        return reg2 ? c_KEEP_REG2 : c_KEEP_REG1;
    endfunction

    // hi = D>>1, lo = D-hi, both carried in 6-bit fields where 64 wraps to 0.
    // Working modulo 64 directly: hi = D[6:1], lo = D[5:0] - D[6:1].
    function automatic logic [15:0] enc_field(input logic [7:0] div, input logic reg2);
        logic [5:0] hi6;
        logic [5:0] lo6;
        hi6 = div[6:1];
        lo6 = div[5:0] - div[6:1];
        if (reg2) begin
            return {8'h00, div[0], (div == 8'd1), 6'b000000};
        end
        return {4'h0, hi6, lo6};
    endfunction

endpackage
`default_nettype wire

// File: rtl/artix7_pll_sync2.sv
`default_nettype none
// ============================================================================
// Module      : artix7_pll_sync2
// Description : Two-flop synchroniser for the asynchronous PLL LOCKED signal.
// Ports       : clk  - destination clock
//               rst  - asynchronous active-high reset, output forced to 0
//               i_d  - asynchronous input
//               o_q  - synchronised output
// Revision    : 1.0 - initial release
// ============================================================================
module artix7_pll_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/artix7_pll_drp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : artix7_pll_drp_ctrl
// Description : Runtime CLKOUTn divider retuning for a PLLE2_ADV via DRP, plus
//               PLL reset/lock sequencing at power-up and after each retune.
// Ports       : clk_i/rst_i          - clock (also DCLK), async active-high rst
//               cfg_req_i/mask/div   - retune request, lane mask, 8b dividers
//               busy_o/done_o/error_o- status (done pulses, error is sticky)
//               locked_o             - synchronised PLL lock
//               pll_rst_o/locked_i   - PLL RST out, PLL LOCKED in
//               drp_*                - DRP master port
// Revision    : 1.0 - initial release
// ============================================================================
module artix7_pll_drp_ctrl
    import artix7_pll_drp_pkg::*;
#(
    parameter int NUM_OUTPUTS  = 6,
    parameter int RST_HOLD     = 16,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int DRDY_TIMEOUT = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cfg_req_i,
    input  logic [NUM_OUTPUTS-1:0]   cfg_mask_i,
    input  logic [8*NUM_OUTPUTS-1:0] cfg_div_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     error_o,
    output logic                     locked_o,
    output logic                     pll_rst_o,
    input  logic                     pll_locked_i,
    output logic [6:0]               drp_daddr_o,
    output logic                     drp_den_o,
    output logic                     drp_dwe_o,
    output logic [15:0]              drp_di_o,
    input  logic [15:0]              drp_do_i,
    input  logic                     drp_drdy_i
);

    localparam logic [15:0] c_RST_LAST  = 16'(RST_HOLD - 1);
    localparam logic [15:0] c_LOCK_LAST = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] c_DRDY_LAST = 16'(DRDY_TIMEOUT - 1);
    localparam logic [2:0]  c_LANES     = 3'(NUM_OUTPUTS);

    state_t                   r_state;
    state_t                   w_state_next;
    logic [15:0]              r_timer;
    logic [2:0]               r_lane;
    logic [2:0]               w_lane_next;
    logic                     r_reg2;
    logic                     w_reg2_next;
    logic [NUM_OUTPUTS-1:0]   r_mask;
    logic [8*NUM_OUTPUTS-1:0] r_div;
    logic [15:0]              r_rdata;
    logic                     r_pll_rst;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_error;
    logic                     w_error_next;
    logic                     w_locked;
    logic [NUM_OUTPUTS-1:0]   w_lane_bad;
    logic                     w_cfg_bad;
    logic                     w_capture;
    logic [7:0]               w_mask_pad;
    logic [63:0]              w_div_pad;
    logic [7:0]               w_cur_div;

    artix7_pll_sync2 u_lock_sync (
        .clk (clk_i),
        .rst (rst_i),
        .i_d (pll_locked_i),
        .o_q (w_locked)
    );

    // A lane is illegal only when it is selected for rewrite.
    for (genvar n = 0; n < NUM_OUTPUTS; n++) begin : g_lane_check
        logic [7:0] w_lane_div;
        assign w_lane_div    = cfg_div_i[8*n +: 8];
        assign w_lane_bad[n] = cfg_mask_i[n] && ((w_lane_div == 8'd0) || (w_lane_div > 8'd128));
    end

    assign w_cfg_bad  = |w_lane_bad;
    assign w_capture  = (r_state == ST_IDLE) && cfg_req_i && !w_cfg_bad;
    // Zero-padded views let the 3-bit lane index address any lane count.
    assign w_mask_pad = 8'(r_mask);
    assign w_div_pad  = 64'(r_div);
    assign w_cur_div  = w_div_pad[{r_lane, 3'b000} +: 8];

    always_comb begin
        w_state_next = r_state;
        w_lane_next  = r_lane;
        w_reg2_next  = r_reg2;
        w_error_next = r_error;
        case (r_state)
            ST_INIT: begin
                if (r_timer == c_RST_LAST) w_state_next = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (w_locked) begin
                    w_state_next = ST_IDLE;
                end else if (r_timer == c_LOCK_LAST) begin
                    w_state_next = ST_IDLE;
                    w_error_next = 1'b1;
                end
            end
            ST_IDLE: begin
                if (cfg_req_i) begin
                    if (w_cfg_bad) begin
                        w_error_next = 1'b1;
                    end else begin
                        w_error_next = 1'b0;
                        w_lane_next  = 3'd0;
                        w_reg2_next  = 1'b0;
                        w_state_next = ST_SEL;
                    end
                end
            end
            ST_SEL: begin
                if (r_lane >= c_LANES) begin
                    w_state_next = ST_RELEASE;
                end else if (!w_mask_pad[r_lane]) begin
                    w_lane_next = r_lane + 3'd1;
                end else begin
                    w_reg2_next  = 1'b0;
                    w_state_next = ST_RD;
                end
            end
            ST_RD: w_state_next = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (drp_drdy_i) begin
                    w_state_next = ST_WR;
                end else if (r_timer == c_DRDY_LAST) begin
                    w_error_next = 1'b1;
                    w_state_next = ST_RELEASE;
                end
            end
            ST_WR: w_state_next = ST_WR_WAIT;
            ST_WR_WAIT: begin
                if (drp_drdy_i) begin
                    if (!r_reg2) begin
                        w_reg2_next  = 1'b1;
                        w_state_next = ST_RD;
                    end else begin
                        w_reg2_next  = 1'b0;
                        w_lane_next  = r_lane + 3'd1;
                        w_state_next = ST_SEL;
                    end
                end else if (r_timer == c_DRDY_LAST) begin
                    w_error_next = 1'b1;
                    w_state_next = ST_RELEASE;
                end
            end
            // RELEASE always waits a full hold window; the PLL has already been
            // in reset for the DRP phase, so its total reset time exceeds RST_HOLD.
            ST_RELEASE: begin
                if (r_timer == c_RST_LAST) w_state_next = ST_WAIT_LOCK;
            end
            default: w_state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_INIT;
            r_timer   <= 16'd0;
            r_lane    <= 3'd0;
            r_reg2    <= 1'b0;
            r_mask    <= '0;
            r_div     <= '0;
            r_rdata   <= 16'd0;
            r_pll_rst <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_lane  <= w_lane_next;
            r_reg2  <= w_reg2_next;
            r_error <= w_error_next;
            // One timer serves every state: restart on each state change.
            if (w_state_next != r_state) begin
                r_timer <= 16'd0;
            end else if (r_timer != 16'hFFFF) begin
                r_timer <= r_timer + 16'd1;
            end
            if (w_capture) begin
                r_mask <= cfg_mask_i;
                r_div  <= cfg_div_i;
            end
            if ((r_state == ST_RD_WAIT) && drp_drdy_i) r_rdata <= drp_do_i;
            // PLL reset is registered so the async RST pin never sees decode glitches.
            r_pll_rst <= !(w_state_next inside {ST_WAIT_LOCK, ST_IDLE});
            r_busy    <= (w_state_next != ST_IDLE);
            r_done    <= (r_state == ST_WAIT_LOCK) && w_locked;
        end
    end

    // DRP is synchronous to clk_i, so these outputs decode the state directly.
    assign drp_den_o   = (r_state == ST_RD) || (r_state == ST_WR);
    assign drp_dwe_o   = (r_state == ST_WR);
    assign drp_daddr_o = drp_den_o ? drp_addr(r_lane, r_reg2) : 7'd0;
    assign drp_di_o    = drp_dwe_o ? ((r_rdata & keep_mask(r_reg2)) | enc_field(w_cur_div, r_reg2))
                                   : 16'd0;

    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign error_o   = r_error;
    assign locked_o  = w_locked;
    assign pll_rst_o = r_pll_rst;

endmodule
`default_nettype wire
